inst_encoder32: RTL and testbench

Streaming RV32I encoder for the R-type and I-type ALU groups. It is the inverse of the instruction decode unit. It accepts an operation index plus rd/rs1/rs2/imm fields and emits a 32-bit instruction word with a word-aligned write address. It sits between the test/boot program generator and the instruction-memory write port, and buffers words in a small FIFO under valid/ready backpressure.

---
 rtl/rv32_enc_pkg.sv | 25 ++
 rtl/enc_fifo.sv | 38 +++
 rtl/inst_encoder32.sv | 71 +++++++
 tb/tb_inst_encoder32.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/rv32_enc_pkg.sv
// rv32_enc_pkg: opcodes, op indices and funct3/funct7 lookups for the RV32I ALU encoder.
package rv32_enc_pkg;
  localparam logic [6:0] OPC_R_ALU = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU = 7'b0010011;
  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_XOR = 5'd2, OP_OR = 5'd3, OP_AND = 5'd4;
  localparam logic [4:0] OP_SLL = 5'd5, OP_SRL = 5'd6, OP_SRA = 5'd7, OP_SLT = 5'd8, OP_SLTU = 5'd9;
  localparam logic [4:0] OP_ADDI = 5'd10, OP_XORI = 5'd11, OP_ORI = 5'd12, OP_ANDI = 5'd13;
  localparam logic [4:0] OP_SLLI = 5'd14, OP_SRLI = 5'd15, OP_SRAI = 5'd16, OP_SLTI = 5'd17, OP_SLTIU = 5'd18;
  localparam logic [4:0] NR_OP = 5'd19;
  function automatic logic [2:0] funct3(input logic [4:0] op);
    case (op)
      OP_SLL, OP_SLLI: return 3'd1;
      OP_SLT, OP_SLTI: return 3'd2;
      OP_SLTU, OP_SLTIU: return 3'd3;
      OP_XOR, OP_XORI: return 3'd4;
      OP_SRL, OP_SRA, OP_SRLI, OP_SRAI: return 3'd5;
      OP_OR, OP_ORI: return 3'd6;
      OP_AND, OP_ANDI: return 3'd7;
      default: return 3'd0;
    endcase
  endfunction
  function automatic logic [6:0] funct7(input logic [4:0] op);
    return (op == OP_SUB || op == OP_SRA || op == OP_SRAI) ? 7'h20 : 7'h00;
  endfunction
endpackage

// File: rtl/enc_fifo.sv
// enc_fifo: synchronous FIFO with full/empty flags and a synchronous flush.
module enc_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(do_push);
      rp <= rp + (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/inst_encoder32.sv
// inst_encoder32: streaming RV32I R/I-type ALU encoder feeding a word-addressed FIFO.
// Optional macro IENC_IMM_CHECK_EN rejects out-of-range immediates/shamts instead of truncating.
module inst_encoder32
  import rv32_enc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_op,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [31:0]           in_imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_inst,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  err,
  output logic [7:0]            err_cnt
);
  logic full, empty, is_r, is_shi, imm_ok, legal, accept, push;
  logic [31:0] inst;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [31+ADDR_WIDTH:0] dout;
  assign is_r = in_op <= OP_SLTU;
  assign is_shi = in_op >= OP_SLLI && in_op <= OP_SRAI;
`ifdef IENC_IMM_CHECK_EN
  // sign-extension of imm[11] must cover all upper bits to fit 12-bit signed
  assign imm_ok = is_r || (is_shi ? ~|in_imm[31:5] : (&in_imm[31:11] || ~|in_imm[31:11]));
`else
  logic unused_imm;
  assign unused_imm = ^in_imm[31:12];
  assign imm_ok = 1'b1;
`endif
  assign legal = in_op < NR_OP && imm_ok;
  assign inst = is_r ? {funct7(in_op), in_rs2, in_rs1, funct3(in_op), in_rd, OPC_R_ALU}
              : is_shi ? {funct7(in_op), in_imm[4:0], in_rs1, funct3(in_op), in_rd, OPC_I_ALU}
              : {in_imm[11:0], in_rs1, funct3(in_op), in_rd, OPC_I_ALU};
  assign in_ready = !full;
  assign accept = in_valid && in_ready;
  assign push = accept && legal && !clr;
  enc_fifo #(.W(32 + ADDR_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .clr(clr), .push(push), .din({inst, addr_cnt}),
    .pop(out_ready), .dout(dout), .full(full), .empty(empty)
  );
  assign out_valid = !empty;
  assign out_inst = empty ? '0 : dout[31+ADDR_WIDTH:ADDR_WIDTH];
  assign out_addr = empty ? '0 : dout[ADDR_WIDTH-1:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr_cnt <= BASE_ADDR;
      err <= 1'b0;
      err_cnt <= '0;
    end else if (clr) begin
      addr_cnt <= BASE_ADDR;
      err <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (push) addr_cnt <= addr_cnt + ADDR_WIDTH'(4);
      if (accept && !legal) begin
        err <= 1'b1;
        err_cnt <= err_cnt + 8'(err_cnt != 8'hFF);
      end
    end
endmodule

// File: tb/tb_inst_encoder32.sv
// tb_inst_encoder32: directed self-checking bench for inst_encoder32.
module tb_inst_encoder32;
  logic clk = 0, rst = 1, clr = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, err;
  logic [4:0] in_op = 0, in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic [31:0] in_imm = 0, out_inst, out_addr;
  logic [7:0] err_cnt;
  int errs = 0, checks = 0;
  logic [31:0] exp_addr = 32'h8000_0000;
  inst_encoder32 dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
    .err(err), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  task automatic send(input logic [4:0] op, rd, rs1, rs2, input logic [31:0] imm);
    @(negedge clk);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_valid = 1;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    if (!in_ready) begin errs++; checks++; $display("FAIL send_timeout in_ready=%b want 1", in_ready); end
    @(posedge clk); #1 in_valid = 0;
  endtask
  task automatic recv(output logic [31:0] inst, output logic [31:0] addr, output bit ok);
    @(negedge clk);
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
    ok = out_valid; inst = out_inst; addr = out_addr;
    if (ok) begin out_ready = 1; @(posedge clk); #1 out_ready = 0; end
  endtask
  task automatic test_reset;
    #1;
    checks++; if (out_valid !== 0 || in_ready !== 1) begin errs++; $display("FAIL rst_async out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    checks++; if (out_valid !== 0) begin errs++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_inst !== 0 || out_addr !== 0) begin errs++; $display("FAIL reset_data got %h@%h want 0@0", out_inst, out_addr); end
    checks++; if (err !== 0 || err_cnt !== 0) begin errs++; $display("FAIL reset_err got %b/%0d want 0/0", err, err_cnt); end
  endtask
  task automatic test_encode;
    logic [4:0] op [8] = '{5'd0, 5'd1, 5'd10, 5'd16, 5'd2, 5'd13, 5'd9, 5'd14};
    logic [4:0] rd [8] = '{5'd3, 5'd5, 5'd1, 5'd10, 5'd1, 5'd4, 5'd31, 5'd1};
    logic [4:0] r1 [8] = '{5'd1, 5'd6, 5'd0, 5'd11, 5'd2, 5'd5, 5'd31, 5'd1};
    logic [4:0] r2 [8] = '{5'd2, 5'd7, 5'd9, 5'd9, 5'd3, 5'd9, 5'd31, 5'd9};
    logic [31:0] im [8] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'h7FF, 32'd0, 32'd31};
    logic [31:0] ex [8] = '{32'h002081B3, 32'h407302B3, 32'hFFF00093, 32'h4035D513,
                            32'h003140B3, 32'h7FF2F213, 32'h01FFBFB3, 32'h01F09093};
    logic [31:0] inst, addr;
    bit ok;
    for (int i = 0; i < 8; i++) begin
      send(op[i], rd[i], r1[i], r2[i], im[i]);
      recv(inst, addr, ok);
      checks++; if (!ok || inst !== ex[i]) begin errs++; $display("FAIL enc_inst[%0d] got %h want %h", i, inst, ex[i]); end
      checks++; if (addr !== exp_addr) begin errs++; $display("FAIL enc_addr[%0d] got %h want %h", i, addr, exp_addr); end
      exp_addr += 4;
    end
  endtask
  task automatic test_error;
    logic [31:0] inst, addr;
    bit ok;
    send(5'd25, 5'd1, 5'd1, 5'd1, 32'd0);
    @(negedge clk);
    checks++; if (out_valid !== 0) begin errs++; $display("FAIL err_nopush out_valid=%b want 0", out_valid); end
    checks++; if (err !== 1 || err_cnt !== 1) begin errs++; $display("FAIL err_set got %b/%0d want 1/1", err, err_cnt); end
    send(5'd2, 5'd1, 5'd2, 5'd3, 32'd0);
    recv(inst, addr, ok);
    checks++; if (!ok || inst !== 32'h003140B3 || addr !== exp_addr) begin errs++; $display("FAIL err_next got %h@%h want 003140b3@%h", inst, addr, exp_addr); end
    exp_addr += 4;
    send(5'd10, 5'd1, 5'd0, 5'd0, 32'd4096);
`ifdef IENC_IMM_CHECK_EN
    @(negedge clk);
    checks++; if (out_valid !== 0 || err_cnt !== 2) begin errs++; $display("FAIL imm_range out_valid=%b err_cnt=%0d want 0/2", out_valid, err_cnt); end
    send(5'd15, 5'd1, 5'd1, 5'd0, 32'd32);
    @(negedge clk);
    checks++; if (out_valid !== 0 || err_cnt !== 3) begin errs++; $display("FAIL shamt_range out_valid=%b err_cnt=%0d want 0/3", out_valid, err_cnt); end
`else
    recv(inst, addr, ok);
    checks++; if (!ok || inst !== 32'h00000093 || addr !== exp_addr) begin errs++; $display("FAIL imm_trunc got %h@%h want 00000093@%h", inst, addr, exp_addr); end
    exp_addr += 4;
`endif
    for (int i = 0; i < 260; i++) send(5'd31, 5'd0, 5'd0, 5'd0, 32'd0);
    @(negedge clk);
    checks++; if (err_cnt !== 8'd255 || err !== 1) begin errs++; $display("FAIL err_sat got %b/%0d want 1/255", err, err_cnt); end
  endtask
  task automatic test_backpressure;
    logic [31:0] inst, addr, base;
    bit ok;
    base = exp_addr;
    for (int i = 0; i < 4; i++) send(5'd0, 5'(i + 1), 5'd0, 5'd0, 32'd0);
    @(negedge clk);
    checks++; if (in_ready !== 0 || out_valid !== 1) begin errs++; $display("FAIL bp_full in_ready=%b out_valid=%b want 0/1", in_ready, out_valid); end
    in_op = 5'd0; in_rd = 5'd5; in_rs1 = 0; in_rs2 = 0; in_imm = 0; in_valid = 1; out_ready = 1;
    #1;
    checks++; if (in_ready !== 0) begin errs++; $display("FAIL bp_conservative in_ready=%b want 0", in_ready); end
    checks++; if (out_inst !== 32'h000000B3 || out_addr !== base) begin errs++; $display("FAIL bp_head got %h@%h want 000000b3@%h", out_inst, out_addr, base); end
    @(posedge clk); #1 out_ready = 0;
    @(negedge clk);
    checks++; if (in_ready !== 1) begin errs++; $display("FAIL bp_release in_ready=%b want 1", in_ready); end
    @(posedge clk); #1 in_valid = 0;
    for (int i = 1; i < 5; i++) begin
      recv(inst, addr, ok);
      checks++; if (!ok || inst !== ((32'(i + 1) << 7) | 32'h33) || addr !== base + 32'(4 * i)) begin
        errs++; $display("FAIL bp_drain[%0d] got %h@%h want %h@%h", i, inst, addr, (32'(i + 1) << 7) | 32'h33, base + 32'(4 * i));
      end
    end
    exp_addr = base + 32'h14;
  endtask
  task automatic test_clr;
    logic [31:0] inst, addr;
    bit ok;
    send(5'd0, 5'd1, 5'd0, 5'd0, 32'd0);
    send(5'd0, 5'd2, 5'd0, 5'd0, 32'd0);
    send(5'd30, 5'd0, 5'd0, 5'd0, 32'd0);
    @(negedge clk);
    clr = 1; in_valid = 1; in_op = 5'd0; in_rd = 5'd7;
    @(posedge clk); #1 clr = 0; in_valid = 0;
    @(negedge clk);
    checks++; if (out_valid !== 0 || in_ready !== 1) begin errs++; $display("FAIL clr_flush out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    checks++; if (err !== 0 || err_cnt !== 0) begin errs++; $display("FAIL clr_err got %b/%0d want 0/0", err, err_cnt); end
    exp_addr = 32'h8000_0000;
    send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    recv(inst, addr, ok);
    checks++; if (!ok || inst !== 32'h002081B3 || addr !== 32'h8000_0000) begin errs++; $display("FAIL clr_next got %h@%h want 002081b3@80000000", inst, addr); end
  endtask
  task automatic test_rst;
    logic [31:0] inst, addr;
    bit ok;
    send(5'd0, 5'd1, 5'd0, 5'd0, 32'd0);
    send(5'd0, 5'd2, 5'd0, 5'd0, 32'd0);
    send(5'd29, 5'd0, 5'd0, 5'd0, 32'd0);
    @(negedge clk); #2 rst = 1; #1;
    checks++; if (out_valid !== 0 || out_inst !== 0 || out_addr !== 0) begin errs++; $display("FAIL rst_mid out %b %h@%h want 0 0@0", out_valid, out_inst, out_addr); end
    checks++; if (err !== 0 || err_cnt !== 0 || in_ready !== 1) begin errs++; $display("FAIL rst_mid_err got %b/%0d rdy=%b want 0/0/1", err, err_cnt, in_ready); end
    @(negedge clk); rst = 0;
    send(5'd1, 5'd5, 5'd6, 5'd7, 32'd0);
    recv(inst, addr, ok);
    checks++; if (!ok || inst !== 32'h407302B3 || addr !== 32'h8000_0000) begin errs++; $display("FAIL rst_next got %h@%h want 407302b3@80000000", inst, addr); end
  endtask
  initial begin
    test_reset;
    test_encode;
    test_error;
    test_backpressure;
    test_clr;
    test_rst;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
